// File: rtl/stall_ctrl.sv
// Pipeline hazard controller: load-use, branch, memory wait and halt arbitration.
// Define STALL_STATS_EN to build the lu/br/stall statistics counters.
module stall_ctrl #(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lu,
  input  logic             br_taken,
  input  logic             mem_wait,
  input  logic             halt_req,
  input  logic             go,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             back_en,
  output logic             halted,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int CW = $clog2(STALL_CYCLES) + 1;

  typedef enum logic [1:0] {
    RUN,
    LU_STALL,
    HALT
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          lu_ev;
  logic          br_ev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    back_en     = 1'b0;
    halted      = 1'b0;
    lu_ev       = 1'b0;
    br_ev       = 1'b0;
    if (!rst) begin
      halted = (state == HALT);
      // mem_wait freezes everything, including state and cnt
      if (!mem_wait) begin
        unique case (state)
          RUN: begin
            if (halt_req) begin
              id_ex_flush = 1'b1;
              back_en     = 1'b1;
              state_nx    = HALT;
            end else if (br_taken) begin
              pc_en       = 1'b1;
              if_id_en    = 1'b1;
              if_id_flush = 1'b1;
              id_ex_flush = 1'b1;
              back_en     = 1'b1;
              br_ev       = 1'b1;
            end else if (lu) begin
              id_ex_flush = 1'b1;
              back_en     = 1'b1;
              lu_ev       = 1'b1;
              if (STALL_CYCLES > 1) begin
                state_nx = LU_STALL;
                cnt_nx   = CW'(STALL_CYCLES - 1);
              end
            end else begin
              pc_en    = 1'b1;
              if_id_en = 1'b1;
              back_en  = 1'b1;
            end
          end
          LU_STALL: begin
            if (br_taken) begin
              pc_en       = 1'b1;
              if_id_en    = 1'b1;
              if_id_flush = 1'b1;
              id_ex_flush = 1'b1;
              back_en     = 1'b1;
              br_ev       = 1'b1;
              state_nx    = RUN;
              cnt_nx      = '0;
            end else begin
              id_ex_flush = 1'b1;
              back_en     = 1'b1;
              cnt_nx      = cnt - CW'(1);
              if (cnt == CW'(1)) begin
                state_nx = RUN;
                cnt_nx   = '0;
              end
            end
          end
          HALT: begin
            id_ex_flush = 1'b1;
            back_en     = 1'b1;
            if (go) state_nx = RUN;
          end
          default: begin
            state_nx = RUN;
            cnt_nx   = '0;
          end
        endcase
      end
    end
  end

`ifdef STALL_STATS_EN
  localparam logic [CNT_W-1:0] CMAX = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lu_cnt    <= '0;
      br_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      if (lu_ev && lu_cnt != CMAX)
        lu_cnt <= lu_cnt + 1'b1;
      if (br_ev && br_cnt != CMAX)
        br_cnt <= br_cnt + 1'b1;
      if (!pc_en && stall_cnt != CMAX)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  logic stats_unused;
  assign stats_unused = lu_ev ^ br_ev;
  assign lu_cnt    = '0;
  assign br_cnt    = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Scoreboard bench for stall_ctrl: STALL_CYCLES=1 and =3 instances side by side.
// A bubble-count reference model predicts strobes and counters per cycle.
module tb_stall_ctrl;

  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lu = 1'b0;
  logic br_taken = 1'b0;
  logic mem_wait = 1'b0;
  logic halt_req = 1'b0;
  logic go = 1'b0;

  logic [5:0]       o1, o3;
  logic [CNT_W-1:0] lc1, bc1, sc1;
  logic [CNT_W-1:0] lc3, bc3, sc3;

  always #5 clk = ~clk;

  stall_ctrl #(.STALL_CYCLES(1), .CNT_W(CNT_W)) u1 (
    .clk(clk), .rst(rst), .lu(lu), .br_taken(br_taken),
    .mem_wait(mem_wait), .halt_req(halt_req), .go(go),
    .pc_en(o1[5]), .if_id_en(o1[4]), .if_id_flush(o1[3]),
    .id_ex_flush(o1[2]), .back_en(o1[1]), .halted(o1[0]),
    .lu_cnt(lc1), .br_cnt(bc1), .stall_cnt(sc1)
  );

  stall_ctrl #(.STALL_CYCLES(3), .CNT_W(CNT_W)) u3 (
    .clk(clk), .rst(rst), .lu(lu), .br_taken(br_taken),
    .mem_wait(mem_wait), .halt_req(halt_req), .go(go),
    .pc_en(o3[5]), .if_id_en(o3[4]), .if_id_flush(o3[3]),
    .id_ex_flush(o3[2]), .back_en(o3[1]), .halted(o3[0]),
    .lu_cnt(lc3), .br_cnt(bc3), .stall_cnt(sc3)
  );

  typedef struct {
    logic [5:0] o;
    longint     lu;
    longint     br;
    longint     st;
  } exp_t;

  exp_t q[2][$];

  int     bub[2];
  bit     hl[2];
  longint clu[2], cbr[2], cst[2];
  int     nvec = 0;
  int     nerr = 0;

  localparam longint CMAX = (64'd1 << CNT_W) - 1;

  function automatic longint sat(input longint v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  // Strobe order: pc_en if_id_en if_id_flush id_ex_flush back_en halted
  localparam logic [5:0] O_RUN = 6'b110010;
  localparam logic [5:0] O_BR  = 6'b111110;
  localparam logic [5:0] O_BUB = 6'b000110;

  task automatic model(input int k, input int sc);
    exp_t e;
    if (rst) begin
      bub[k] = 0;
      hl[k]  = 1'b0;
      clu[k] = 0;
      cbr[k] = 0;
      cst[k] = 0;
      e.o  = '0;
      e.lu = 0;
      e.br = 0;
      e.st = 0;
      q[k].push_back(e);
      return;
    end
    e.lu = clu[k];
    e.br = cbr[k];
    e.st = cst[k];
    if (mem_wait) begin
      e.o    = {5'b0, hl[k]};
      cst[k] = sat(cst[k]);
    end else if (hl[k]) begin
      e.o    = O_BUB | 6'b000001;
      cst[k] = sat(cst[k]);
      if (go) hl[k] = 1'b0;
    end else if (bub[k] > 0) begin
      if (br_taken) begin
        e.o    = O_BR;
        cbr[k] = sat(cbr[k]);
        bub[k] = 0;
      end else begin
        e.o    = O_BUB;
        cst[k] = sat(cst[k]);
        bub[k] = bub[k] - 1;
      end
    end else if (halt_req) begin
      e.o    = O_BUB;
      cst[k] = sat(cst[k]);
      hl[k]  = 1'b1;
    end else if (br_taken) begin
      e.o    = O_BR;
      cbr[k] = sat(cbr[k]);
    end else if (lu) begin
      e.o    = O_BUB;
      clu[k] = sat(clu[k]);
      cst[k] = sat(cst[k]);
      bub[k] = sc - 1;
    end else begin
      e.o = O_RUN;
    end
    q[k].push_back(e);
  endtask

  task automatic cyc(input logic r, input logic l, input logic b,
                     input logic m, input logic h, input logic g);
    @(posedge clk);
    #1;
    rst      = r;
    lu       = l;
    br_taken = b;
    mem_wait = m;
    halt_req = h;
    go       = g;
    model(0, 1);
    model(1, 3);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  function automatic void chk(input string nm, input longint act,
                              input longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endfunction

  function automatic void chk_dut(input string nm, input exp_t e,
                                  input logic [5:0] o, input longint l,
                                  input longint b, input longint s);
    chk({nm, ".strobes"}, longint'(o), longint'(e.o));
`ifdef STALL_STATS_EN
    chk({nm, ".lu_cnt"}, l, e.lu);
    chk({nm, ".br_cnt"}, b, e.br);
    chk({nm, ".stall_cnt"}, s, e.st);
`else
    chk({nm, ".lu_cnt"}, l, 0);
    chk({nm, ".br_cnt"}, b, 0);
    chk({nm, ".stall_cnt"}, s, 0);
`endif
  endfunction

  always @(negedge clk) begin
    if (q[0].size() > 0) begin
      exp_t e;
      e = q[0].pop_front();
      chk_dut("sc1", e, o1, lc1, bc1, sc1);
    end
    if (q[1].size() > 0) begin
      exp_t e;
      e = q[1].pop_front();
      chk_dut("sc3", e, o3, lc3, bc3, sc3);
    end
  end

  initial begin
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    idle(3);
    cyc(0, 1, 0, 0, 0, 0);
    idle(4);
    cyc(0, 1, 1, 0, 0, 0);
    idle(2);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    idle(4);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    idle(2);
    cyc(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1);
    idle(3);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    idle(2);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) < 1,
          $urandom_range(0, 99) < 25,
          $urandom_range(0, 99) < 12,
          $urandom_range(0, 99) < 10,
          $urandom_range(0, 99) < 3,
          $urandom_range(0, 99) < 20);
    end
    idle(2);
    for (int i = 0; i < 10; i++) begin
      if (q[0].size() == 0 && q[1].size() == 0) break;
      @(negedge clk);
    end
    if (q[0].size() != 0 || q[1].size() != 0) begin
      nerr++;
      $display("FAIL drain: %0d/%0d entries left, expected 0",
               q[0].size(), q[1].size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
